// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation codes,
// FSM state type and the CALC cycle count helper.
package mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  // One result bit is produced per CALC cycle.
  function automatic int calc_cycles(input int width);
    return width;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// WIDTH-step restoring unsigned divider core; one quotient bit per step.
module mdu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo_q, rem_q, dsr_q;
  logic [WIDTH:0]   shifted, diff;

  // Partial remainder is always below the divisor, so the shifted value fits WIDTH+1 bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign diff    = shifted - {1'b0, dsr_q};

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (load) begin
        quo_q <= dividend;
        rem_q <= '0;
        dsr_q <= divisor;
      end else if (step) begin
        if (!diff[WIDTH]) begin
          rem_q <= diff[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_q <= shifted[WIDTH-1:0];
          quo_q <= {quo_q[WIDTH-2:0], 1'b0};
        end
      end
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Divide support is built only when MDU_DIV_EN is defined.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       MDUOp,
  input  logic             start,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int               CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(calc_cycles(WIDTH) - 1);

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic is_signed);
    return (is_signed && v[WIDTH-1]) ? -v : v;
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg_w(input logic [WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v, input logic neg);
    return neg ? -v : v;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               accept, accept_mul, wr_hi, wr_lo;
  logic               op_signed;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH-1:0]   mcand_q, prod_hi_q, prod_lo_q;
  logic [WIDTH:0]     add_sum;
  logic               neg_res_q;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   res_hi, res_lo;
`ifdef MDU_DIV_EN
  logic               accept_div;
  logic               is_div_q, neg_rem_q, div_zero_q, div_ovf_q;
  logic [WIDTH-1:0]   a_q, quo, rem;
`endif

  assign op_signed = ~MDUOp[0];
  assign mag_a     = mag(A, op_signed);
  assign mag_b     = mag(B, op_signed);
  assign busy      = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    accept     = 1'b0;
    accept_mul = 1'b0;
    wr_hi      = 1'b0;
    wr_lo      = 1'b0;
`ifdef MDU_DIV_EN
    accept_div = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          case (MDUOp)
            OP_MULT, OP_MULTU: begin
              accept     = 1'b1;
              accept_mul = 1'b1;
              state_d    = CALC;
            end
`ifdef MDU_DIV_EN
            OP_DIV, OP_DIVU: begin
              accept     = 1'b1;
              accept_div = 1'b1;
              state_d    = CALC;
            end
`endif
            OP_MTHI: wr_hi = 1'b1;
            OP_MTLO: wr_lo = 1'b1;
            default: ;
          endcase
        end
      end
      CALC:    if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)      cnt_q <= CNT_LAST;
      else if (state_q == CALC) cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  // Capture: operand magnitudes and signs; CALC: shift-add one multiplier bit per cycle
  assign add_sum = {1'b0, prod_hi_q} + (prod_lo_q[0] ? {1'b0, mcand_q} : '0);

  always_ff @(posedge clk) begin
    if (accept) neg_res_q <= op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
    if (accept_mul) begin
      mcand_q   <= mag_a;
      prod_hi_q <= '0;
      prod_lo_q <= mag_b;
    end else if (state_q == CALC) begin
      {prod_hi_q, prod_lo_q} <= {add_sum, prod_lo_q[WIDTH-1:1]};
    end
  end

`ifdef MDU_DIV_EN
  always_ff @(posedge clk) begin
    if (accept) begin
      is_div_q   <= accept_div;
      neg_rem_q  <= op_signed & A[WIDTH-1];
      div_zero_q <= (B == '0);
      div_ovf_q  <= op_signed && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
      a_q        <= A;
    end
  end

  mdu_divider #(.WIDTH(WIDTH)) u_divider (
    .clk       (clk),
    .reset     (reset),
    .load      (accept_div),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .step      (state_q == CALC),
    .quotient  (quo),
    .remainder (rem)
  );
`endif

  // FIX: sign correction and divide special cases
  always_comb begin
    prod_fix = cond_neg_2w({prod_hi_q, prod_lo_q}, neg_res_q);
    res_hi   = prod_fix[2*WIDTH-1:WIDTH];
    res_lo   = prod_fix[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (is_div_q) begin
      if (div_zero_q) begin
        res_lo = '1;
        res_hi = a_q;
      end else if (div_ovf_q) begin
        res_lo = a_q;
        res_hi = '0;
      end else begin
        res_lo = cond_neg_w(quo, neg_res_q);
        res_hi = cond_neg_w(rem, neg_rem_q);
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (state_q == FIX) begin
      HI <= res_hi;
      LO <= res_lo;
    end else begin
      if (wr_hi) HI <= A;
      if (wr_lo) LO <= A;
    end
  end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu (WIDTH=32) against an arithmetic reference model;
// divide expectations follow whether MDU_DIV_EN is defined for the build.
module tb_mdu;

`ifdef MDU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic [2:0]  MDUOp = '0;
  logic        start = 1'b0;
  logic        busy;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] hi_m = '0;
  logic [31:0] lo_m = '0;

  mdu #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .start (start),
    .busy  (busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Reference model: architectural effect of one accepted request on HI/LO.
  task automatic model_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                             output bit long_op);
    logic [63:0] r;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    long_op = 1'b0;
    case (op)
      3'd0: begin r = sa * sb; hi_m = r[63:32]; lo_m = r[31:0]; long_op = 1'b1; end
      3'd1: begin r = {32'd0, a} * {32'd0, b}; hi_m = r[63:32]; lo_m = r[31:0]; long_op = 1'b1; end
      3'd2, 3'd3: begin
        if (DIV_EN) begin
          long_op = 1'b1;
          if (b == 32'd0) begin
            lo_m = 32'hFFFF_FFFF; hi_m = a;
          end else if (op == 3'd2 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo_m = a; hi_m = 32'd0;
          end else if (op == 3'd2) begin
            lo_m = 32'(sa / sb); hi_m = 32'(sa % sb);
          end else begin
            lo_m = a / b; hi_m = a % b;
          end
        end
      end
      3'd4: hi_m = a;
      3'd5: lo_m = a;
      default: ;
    endcase
  endtask

  // Present a request for one cycle (called and returning on a falling edge).
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    MDUOp = op; A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; MDUOp = 3'($urandom);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
    issue(3'd0, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
    checks++; if (HI !== 32'd0) begin errors++; $display("FAIL abort_hi: got %h want 0", HI); end
    checks++; if (LO !== 32'd0) begin errors++; $display("FAIL abort_lo: got %h want 0", LO); end
    n = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) n++;
    end
    checks++; if (n != 0) begin errors++; $display("FAIL abort_stays_clear: got %0d bad cycles want 0", n); end
    hi_m = '0; lo_m = '0;
  endtask

  task automatic test_mult();
    int n;
    bit lo_op;
    model_apply(3'd0, 32'hFFFF_FFFE, 32'd3, lo_op);
    issue(3'd0, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d want 33", n); end
    checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
    model_apply(3'd1, 32'hFFFF_FFFE, 32'd3, lo_op);
    issue(3'd1, 32'hFFFF_FFFE, 32'd3);
    wait_done(n);
    checks++; if (n != 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", n); end
    checks++; if (HI !== 32'h0000_0002) begin errors++; $display("FAIL multu_hi: got %h want 00000002", HI); end
    checks++; if (LO !== 32'hFFFF_FFFA) begin errors++; $display("FAIL multu_lo: got %h want fffffffa", LO); end
  endtask

  task automatic test_div();
    int n;
    bit lo_op;
    logic [31:0] hi0, lo0;
`ifdef MDU_DIV_EN
    logic [2:0]  ops [4] = '{3'd2, 3'd3, 3'd3, 3'd2};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'd7, 32'd5, 32'h8000_0000};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] elo [4] = '{32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] ehi [4] = '{32'hFFFF_FFFF, 32'd1, 32'd5, 32'd0};
    for (int i = 0; i < 4; i++) begin
      model_apply(ops[i], as[i], bs[i], lo_op);
      issue(ops[i], as[i], bs[i]);
      wait_done(n);
      checks++; if (n != 33) begin errors++; $display("FAIL div%0d_busy_cycles: got %0d want 33", i, n); end
      checks++; if (LO !== elo[i]) begin errors++; $display("FAIL div%0d_lo: got %h want %h", i, LO, elo[i]); end
      checks++; if (HI !== ehi[i]) begin errors++; $display("FAIL div%0d_hi: got %h want %h", i, HI, ehi[i]); end
    end
`else
    hi0 = HI; lo0 = LO;
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    n = 0;
    repeat (3) begin
      if (busy !== 1'b0) n++;
      @(negedge clk);
    end
    checks++; if (n != 0) begin errors++; $display("FAIL nodiv_busy: got %0d busy cycles want 0", n); end
    checks++; if (HI !== hi0) begin errors++; $display("FAIL nodiv_hi: got %h want %h", HI, hi0); end
    checks++; if (LO !== lo0) begin errors++; $display("FAIL nodiv_lo: got %h want %h", LO, lo0); end
`endif
  endtask

  task automatic test_handshake();
    int n;
    bit lo_op;
    model_apply(3'd0, 32'h0001_0001, 32'h0010_0003, lo_op);
    issue(3'd0, 32'h0001_0001, 32'h0010_0003);
    repeat (2) @(negedge clk);
    MDUOp = 3'd4; A = 32'h1234; start = 1'b1;
    repeat (3) @(negedge clk);
    start = 1'b0;
    wait_done(n);
    checks++; if (HI !== hi_m) begin errors++; $display("FAIL mthi_busy_hi: got %h want %h", HI, hi_m); end
    checks++; if (LO !== lo_m) begin errors++; $display("FAIL mthi_busy_lo: got %h want %h", LO, lo_m); end
    model_apply(3'd5, 32'hABCD, 32'd0, lo_op);
    issue(3'd5, 32'hABCD, 32'd0);
    checks++; if (LO !== 32'h0000_ABCD) begin errors++; $display("FAIL mtlo_lo: got %h want 0000abcd", LO); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    checks++; if (HI !== hi_m) begin errors++; $display("FAIL mtlo_hi_kept: got %h want %h", HI, hi_m); end
  endtask

  task automatic test_back_to_back();
    int n, c0;
    bit lo_op;
    logic [31:0] a1, b1, a2, b2;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    c0 = cyc;
    model_apply(3'd0, a1, b1, lo_op);
    issue(3'd0, a1, b1);
    wait_done(n);
    checks++; if (cyc - c0 != 34) begin errors++; $display("FAIL b2b_first_cycle: got %0d want 34", cyc - c0); end
    checks++; if ({HI, LO} !== {hi_m, lo_m}) begin errors++; $display("FAIL b2b_first: got %h%h want %h%h", HI, LO, hi_m, lo_m); end
    model_apply(3'd1, a2, b2, lo_op);
    issue(3'd1, a2, b2);
    wait_done(n);
    checks++; if (cyc - c0 != 68) begin errors++; $display("FAIL b2b_second_cycle: got %0d want 68", cyc - c0); end
    checks++; if ({HI, LO} !== {hi_m, lo_m}) begin errors++; $display("FAIL b2b_second: got %h%h want %h%h", HI, LO, hi_m, lo_m); end
  endtask

  task automatic test_random();
    int n;
    bit long_op;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 5));
        default: ;
      endcase
      model_apply(op, a, b, long_op);
      issue(op, a, b);
      if (long_op) begin
        wait_done(n);
        checks++; if (n != 33) begin errors++; $display("FAIL rand%0d_op%0d_busy_cycles: got %0d want 33", i, op, n); end
      end else begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d_op%0d_busy: got %b want 0", i, op, busy); end
      end
      checks++; if (HI !== hi_m) begin errors++; $display("FAIL rand%0d_op%0d_hi: got %h want %h (a=%h b=%h)", i, op, HI, hi_m, a, b); end
      checks++; if (LO !== lo_m) begin errors++; $display("FAIL rand%0d_op%0d_lo: got %h want %h (a=%h b=%h)", i, op, LO, lo_m, a, b); end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_mult();
    test_div();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
